// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The master modport is the loader side; the slave modport is the stream source / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 9
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_waddr,
        output mem_wdata
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian program image from a byte stream into
// instruction memory, one write per 32-bit word, holding the CPU off meanwhile.
module imem_loader #(
    parameter int DEPTH       = 512,
    parameter int ADDR_W      = 9,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    imem_loader_if.master   bus,
    output logic            o_cpu_hold,
    output logic            o_done,
    output logic            o_error,
    output logic [ADDR_W:0] o_word_count
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERR
    } state_t;

    state_t            r_state;
    logic [7:0]        r_lenLo;
    logic [15:0]       r_len;
    logic [31:0]       r_wbuf;
    logic [1:0]        r_bidx;
    logic [ADDR_W-1:0] r_widx;
    logic [CNT_W-1:0]  r_idle;

    logic              r_byteReady;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memWaddr;
    logic [31:0]       r_memWdata;
    logic              r_cpuHold;
    logic              r_done;
    logic              r_error;
    logic [ADDR_W:0]   r_wordCount;

    logic              w_xfer;
    logic [15:0]       w_len;
    logic [31:0]       w_word;
    logic              w_lastWord;
    logic              w_timeout;

    assign w_xfer     = bus.byte_valid & r_byteReady;
    assign w_len      = {bus.byte_data, r_lenLo};
    assign w_word     = {bus.byte_data, r_wbuf[31:8]};
    assign w_lastWord = (16'(r_widx) == (r_len - 16'd1));
    // The counter holds the idle edges seen so far, so this edge is the TIMEOUT_CYC-th.
    assign w_timeout  = !w_xfer && (r_idle == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lenLo     <= '0;
            r_len       <= '0;
            r_wbuf      <= '0;
            r_bidx      <= '0;
            r_widx      <= '0;
            r_idle      <= '0;
            r_byteReady <= 1'b0;
            r_memWe     <= 1'b0;
            r_memWaddr  <= '0;
            r_memWdata  <= '0;
            r_cpuHold   <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_wordCount <= '0;
        end else begin
            r_memWe <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE, ERR: begin
                    if (i_start) begin
                        r_state     <= LEN_LO;
                        r_error     <= 1'b0;
                        r_wordCount <= '0;
                        r_widx      <= '0;
                        r_bidx      <= '0;
                        r_idle      <= '0;
                        r_byteReady <= 1'b1;
                        r_cpuHold   <= 1'b1;
                    end
                end
                LEN_LO, LEN_HI, DATA: begin
                    if (w_xfer) begin
                        r_idle <= '0;
                    end else begin
                        r_idle <= r_idle + CNT_W'(1);
                    end
                    if (w_timeout) begin
                        r_state     <= ERR;
                        r_error     <= 1'b1;
                        r_byteReady <= 1'b0;
                    end else if (w_xfer) begin
                        if (r_state == LEN_LO) begin
                            r_lenLo <= bus.byte_data;
                            r_state <= LEN_HI;
                        end else if (r_state == LEN_HI) begin
                            r_len <= w_len;
                            if (w_len == 16'd0 || w_len > 16'(DEPTH)) begin
                                r_state     <= ERR;
                                r_error     <= 1'b1;
                                r_byteReady <= 1'b0;
                            end else begin
                                r_state <= DATA;
                            end
                        end else begin
                            r_wbuf <= w_word;
                            r_bidx <= r_bidx + 2'd1;
                            if (r_bidx == 2'd3) begin
                                r_memWe     <= 1'b1;
                                r_memWaddr  <= r_widx;
                                r_memWdata  <= w_word;
                                r_widx      <= r_widx + ADDR_W'(1);
                                r_wordCount <= r_wordCount + (ADDR_W + 1)'(1);
                                if (w_lastWord) begin
                                    r_state     <= DONE;
                                    r_done      <= 1'b1;
                                    r_byteReady <= 1'b0;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_cpuHold <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_byteReady <= 1'b0;
                    r_cpuHold   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready = r_byteReady;
    assign bus.mem_we     = r_memWe;
    assign bus.mem_waddr  = r_memWaddr;
    assign bus.mem_wdata  = r_memWdata;
    assign o_cpu_hold     = r_cpuHold;
    assign o_done         = r_done;
    assign o_error        = r_error;
    assign o_word_count   = r_wordCount;

endmodule
